// File: rtl/weight_row_streamer.sv
// Two-entry FIFO with registered storage; the head entry drives the consumer side.
// Latency: push visible on pop side the cycle after the push edge.
// Backpressure: pop_rdy low holds the head; pushes beyond capacity are dropped unless a pop frees a slot.
module wrs_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_vld,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop_rdy,
    output logic                         pop_vld,
    output logic [W-1:0]                 pop_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_vld = (count != '0);
    assign pop_dat = mem[rptr];
    assign do_pop  = pop_vld && pop_rdy;
    assign do_push = push_vld && ((count != ($clog2(DEPTH+1))'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            // Cleared so the consumer-side outputs read as zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr] <= push_dat;
                wptr      <= ptr_next(wptr);
            end
            if (do_pop) begin
                rptr <= ptr_next(rptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Reloadable weight row store streaming a wrapping row range, replayed num_passes times.
// Latency: start edge E0, first read at E1, first beat valid after E2; 1 beat/cycle with ready high.
// Backpressure: reads issue only while FIFO occupancy plus in-flight read stays below 2; beats hold while stalled.
module weight_row_streamer #(
    parameter int LANE_W = 16,
    parameter int LANES  = 16,
    parameter int DEPTH  = 28,
    parameter int PASS_W = 8,
    localparam int RW    = LANE_W * LANES,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_row,
    input  logic [RW-1:0]     wr_data,
    input  logic              start,
    input  logic [AW-1:0]     start_row,
    input  logic [AW:0]       num_rows,
    input  logic [PASS_W-1:0] num_passes,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RW-1:0]     out_data,
    output logic [AW-1:0]     out_row,
    output logic              out_last,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    typedef struct packed {
        logic [RW-1:0] data;
        logic [AW-1:0] row;
        logic          last;
    } beat_t;

    state_t            state;
    logic [RW-1:0]     mem [DEPTH];
    logic [AW-1:0]     row_ptr;
    logic [AW:0]       k_cnt;
    logic [PASS_W-1:0] pass_cnt;
    logic [AW-1:0]     start_row_q;
    logic [AW:0]       num_rows_q;
    logic [PASS_W-1:0] num_passes_q;

    logic              rd_vld;
    logic [RW-1:0]     rd_data;
    logic [AW-1:0]     rd_row;
    logic              rd_last;

    beat_t             push_beat;
    beat_t             head_beat;
    logic [1:0]        fifo_cnt;
    logic [2:0]        level;
    logic              pop;
    logic              issue;
    logic              k_last;
    logic              pass_last;
    logic              cmd_ok;
    logic              drain_done;
    logic [AW-1:0]     row_next;

    assign pop       = out_valid && out_ready;
    assign level     = 3'(fifo_cnt) + 3'(rd_vld);
    // A slot freed by this cycle's pop can be refilled by a read issued now.
    assign issue     = (state == S_RUN) && ((level < 3'd2) || ((level == 3'd2) && pop));
    assign k_last    = (k_cnt == num_rows_q - 1'b1);
    assign pass_last = (pass_cnt == num_passes_q - 1'b1);
    assign row_next  = (row_ptr == AW'(DEPTH - 1)) ? '0 : row_ptr + 1'b1;
    assign cmd_ok    = (num_rows != '0) && (32'(num_rows) <= DEPTH)
                    && (32'(start_row) < DEPTH) && (num_passes != '0);
    assign drain_done = (state == S_DRAIN) && !rd_vld
                     && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop));

    // Storage: no reset, read-first on a same-row write.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_row) < DEPTH)) begin
            mem[wr_row] <= wr_data;
        end
        if (issue) begin
            rd_data <= mem[row_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            row_ptr      <= '0;
            k_cnt        <= '0;
            pass_cnt     <= '0;
            start_row_q  <= '0;
            num_rows_q   <= '0;
            num_passes_q <= '0;
            rd_vld       <= 1'b0;
            rd_row       <= '0;
            rd_last      <= 1'b0;
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            rd_vld <= issue;
            if (issue) begin
                rd_row  <= row_ptr;
                rd_last <= k_last;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cmd_ok) begin
                            start_row_q  <= start_row;
                            num_rows_q   <= num_rows;
                            num_passes_q <= num_passes;
                            row_ptr      <= start_row;
                            k_cnt        <= '0;
                            pass_cnt     <= '0;
                            busy         <= 1'b1;
                            state        <= S_RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        if (k_last) begin
                            k_cnt   <= '0;
                            row_ptr <= start_row_q;
                            if (pass_last) begin
                                state <= S_DRAIN;
                            end else begin
                                pass_cnt <= pass_cnt + 1'b1;
                            end
                        end else begin
                            k_cnt   <= k_cnt + 1'b1;
                            row_ptr <= row_next;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign push_beat = '{data: rd_data, row: rd_row, last: rd_last};

    wrs_fifo #(
        .W     ($bits(beat_t)),
        .DEPTH (2)
    ) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (rd_vld),
        .push_dat (push_beat),
        .pop_rdy  (out_ready),
        .pop_vld  (out_valid),
        .pop_dat  (head_beat),
        .count    (fifo_cnt)
    );

    assign out_data = head_beat.data;
    assign out_row  = head_beat.row;
    assign out_last = head_beat.last;
endmodule

// File: tb/tb_weight_row_streamer.sv
// Directed bench for weight_row_streamer: load, full stream, wrap/replay, back-pressure, illegal commands, reset.
module tb_weight_row_streamer;
    localparam int RW = 256;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_row;
    logic [RW-1:0] wr_data;
    logic          start;
    logic [AW-1:0] start_row;
    logic [AW:0]   num_rows;
    logic [7:0]    num_passes;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;
    logic [AW-1:0] out_row;
    logic          out_last;
    logic          done;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [RW-1:0] model [28];

    weight_row_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .start      (start),
        .start_row  (start_row),
        .num_rows   (num_rows),
        .num_passes (num_passes),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_last   (out_last),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] row_pattern(input int r);
        logic [15:0] v;
        v = 16'(r * 3 - 40);
        return {16{v}};
    endfunction

    // Issues one command and follows it to done, checking every handshaked beat against the model.
    task automatic run_cmd(input int sr, input int nr, input int np, input int pct, input int wr_beat);
        int cyc;
        int beats;
        int k;
        int er;
        bit got_done;
        bit stalled;
        logic [RW-1:0] hd;
        logic [AW-1:0] hr;
        logic hl;
        start_row  = AW'(sr);
        num_rows   = (AW+1)'(nr);
        num_passes = 8'(np);
        start      = 1'b1;
        tick();
        start = 1'b0;
        check("busy_on", busy, 1);
        cyc = 0; beats = 0; got_done = 0; stalled = 0;
        hd = '0; hr = '0; hl = 1'b0;
        while (!got_done && cyc < 3000) begin
            if (stalled) begin
                check("stall_hold", {out_valid, out_row, out_last, out_data}, {1'b1, hr, hl, hd});
            end
            if (done) begin
                got_done = 1;
                if (pct >= 100) check("done_latency", cyc, nr * np + 2);
            end else begin
                if (cyc == 3) start = 1'b1;
                out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
                stalled = out_valid && !out_ready;
                hd = out_data; hr = out_row; hl = out_last;
                if (out_valid && out_ready) begin
                    k  = beats % nr;
                    er = (sr + k) % 28;
                    check("beat_row", out_row, er);
                    check("beat_data", out_data, model[er]);
                    check("beat_last", out_last, (k == nr - 1));
                    if (pct >= 100) check("no_bubble", cyc, beats + 2);
                    if (beats == wr_beat) begin
                        wr_en   = 1'b1;
                        wr_row  = AW'(20);
                        wr_data = {16{16'h7fff}};
                        model[20] = {16{16'h7fff}};
                    end
                    beats++;
                end
                tick();
                cyc++;
                start = 1'b0;
                wr_en = 1'b0;
                if (cyc == 4) check("start_busy_no_err", err, 0);
            end
        end
        check("done_seen", got_done, 1);
        check("beat_count", beats, nr * np);
        check("busy_off", busy, 0);
        out_ready = 1'b1;
        tick();
        check("done_one_cycle", done, 0);
        check("idle_no_valid", out_valid, 0);
    endtask

    task automatic illegal(input string tag, input int sr, input int nr, input int np);
        start_row  = AW'(sr);
        num_rows   = (AW+1)'(nr);
        num_passes = 8'(np);
        start      = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_err"}, err, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, out_valid, 0);
        tick();
        check({tag, "_err_clear"}, err, 0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_data = '0; start = 1'b0;
        start_row = '0; num_rows = '0; num_passes = '0; out_ready = 1'b1;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_row", out_row, 0);
        check("rst_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        for (int r = 0; r < 28; r++) begin
            model[r] = row_pattern(r);
            wr_en    = 1'b1;
            wr_row   = AW'(r);
            wr_data  = model[r];
            tick();
        end
        wr_en = 1'b0;
        tick();

        run_cmd(0, 28, 1, 100, -1);
        run_cmd(26, 4, 3, 100, -1);
        run_cmd(26, 4, 3, 40, -1);

        illegal("rows0", 0, 0, 1);
        illegal("rows29", 0, 29, 1);
        illegal("start28", 28, 4, 1);
        illegal("passes0", 0, 4, 0);

        run_cmd(0, 28, 1, 100, 5);
        check("wr_row20_beat", model[20], {16{16'h7fff}});

        start_row = '0; num_rows = 6'd28; num_passes = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 11; c++) tick();
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_row", out_row, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_done", done, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("post_rst_quiet", {done, out_valid, busy}, 3'b000);
        end
        run_cmd(0, 28, 1, 100, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
